// File: rtl/dc_pattern_player.sv
// Pattern RAM player: host-writable table replayed onto a registered DC_X bus at div+1 cycles per step.
// Optional feature: define DC_PINGPONG_EN for up/down (ping-pong) address sweeps.
module dc_pattern_player #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DIV_W = 8
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    input  logic [AW-1:0]    end_addr,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] DC_X,
    output logic             busy,
    output logic             done
);

    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    end_q, end_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             loop_q, loop_d;
    logic             tick;
    logic             wr_ok;
    logic [AW-1:0]    end_clamped;
`ifdef DC_PINGPONG_EN
    logic             dir_q, dir_d;   // 0 = ascending, 1 = descending
`endif

    logic [WIDTH-1:0] ram [DEPTH];

    // The range checks only exist when the address space is larger than the table.
    generate
        if (DEPTH < (2 ** AW)) begin : g_partial
            localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
            assign wr_ok       = (wr_addr <= LAST_ADDR);
            assign end_clamped = (end_addr > LAST_ADDR) ? LAST_ADDR : end_addr;
        end else begin : g_full
            assign wr_ok       = 1'b1;
            assign end_clamped = end_addr;
        end
    endgenerate

    // NOTE: the pattern RAM has no reset so it maps onto block/distributed RAM;
    // its contents are only defined once the host has written them.
    always_ff @(posedge sysclk) begin
        if (wr_en && wr_ok) begin
            ram[wr_addr[RAM_AW-1:0]] <= wr_data;
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        end_d   = end_q;
        presc_d = presc_q;
        div_d   = div_q;
        loop_d  = loop_q;
        tick    = 1'b0;
`ifdef DC_PINGPONG_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    addr_d  = '0;
                    presc_d = '0;
                    end_d   = end_clamped;
                    div_d   = div;
                    loop_d  = loop;
`ifdef DC_PINGPONG_EN
                    dir_d   = 1'b0;
`endif
                end
            end
            S_RUN: begin
                tick = (presc_q == div_q);
                if (stop) begin
                    state_d = S_IDLE;
                end else if (!tick) begin
                    presc_d = presc_q + 1'b1;
                end else begin
                    presc_d = '0;
`ifdef DC_PINGPONG_EN
                    if (!dir_q) begin
                        if (addr_q != end_q) begin
                            addr_d = addr_q + 1'b1;
                        end else if (end_q != '0) begin
                            dir_d  = 1'b1;
                            addr_d = addr_q - 1'b1;
                        end else if (loop_q) begin
                            addr_d = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        // Turning at 0 goes straight to 1 so the end entry is not replayed.
                        if (addr_q != '0) begin
                            addr_d = addr_q - 1'b1;
                        end else if (loop_q) begin
                            dir_d  = 1'b0;
                            addr_d = AW'(1);
                        end else begin
                            state_d = S_DONE;
                        end
                    end
`else
                    if (addr_q != end_q) begin
                        addr_d = addr_q + 1'b1;
                    end else if (loop_q) begin
                        addr_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            presc_q <= '0;
            div_q   <= '0;
            loop_q  <= 1'b0;
`ifdef DC_PINGPONG_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            presc_q <= presc_d;
            div_q   <= div_d;
            loop_q  <= loop_d;
`ifdef DC_PINGPONG_EN
            dir_q   <= dir_d;
`endif
        end
    end

    // DC_X is the RAM read register; it freezes outside RUN.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            DC_X <= '0;
        end else if (state_q == S_RUN) begin
            DC_X <= ram[addr_q[RAM_AW-1:0]];
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_dc_pattern_player.sv
// Self-checking bench for dc_pattern_player: directed vector table, hand sequences,
// and randomized runs against a sequence-based reference model.
module tb_dc_pattern_player;

    localparam int WIDTH = 6;
    localparam int DEPTH = 64;
    localparam int AW    = 7;
    localparam int DIV_W = 8;

    logic             sysclk = 1'b0;
    logic             rst_n  = 1'b1;
    logic             wr_en  = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             start = 1'b0;
    logic             stop  = 1'b0;
    logic             loop  = 1'b0;
    logic [AW-1:0]    end_addr = '0;
    logic [DIV_W-1:0] div = '0;
    logic [WIDTH-1:0] dc_x;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] mem [DEPTH];
    int               m_dcx;

    typedef struct {
        int ea;
        int dv;
        int lp;
        int k;
        int dcx;
        int bsy;
        int dn;
    } vec_t;

    vec_t vecs[$];

    dc_pattern_player #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW),
        .DIV_W(DIV_W)
    ) dut (
        .sysclk  (sysclk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .stop    (stop),
        .loop    (loop),
        .end_addr(end_addr),
        .div     (div),
        .DC_X    (dc_x),
        .busy    (busy),
        .done    (done)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input int ea, input int dv, input int lp, input int k,
                           input int dcx, input int bsy, input int dn);
        vec_t v;
        v.ea = ea; v.dv = dv; v.lp = lp; v.k = k; v.dcx = dcx; v.bsy = bsy; v.dn = dn;
        vecs.push_back(v);
    endtask

    // Called at a falling edge; returns at a falling edge with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge sysclk);
        @(negedge sysclk);
        rst_n = 1'b1;
    endtask

    task automatic write_word(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = WIDTH'(data);
        if (addr < DEPTH) mem[addr] = WIDTH'(data);
        @(negedge sysclk);
        wr_en = 1'b0;
    endtask

    // Returns at the falling edge right after the start edge (run cycle 0).
    task automatic start_run(input int ea, input int dv, input int lp);
        end_addr = AW'(ea);
        div      = DIV_W'(dv);
        loop     = lp[0];
        start    = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
    endtask

    // Randomized playback checked cycle by cycle against the address sequence implied by the rules.
    task automatic random_run(input int run_id);
        int ea;
        int e;
        int dv;
        int lp;
        int p;
        int run_len;
        int stop_at;
        int ms;
        int k;
        int a;
        int idle_seen;
        bit finished;
        int seq_one[$];
        int seq_loop[$];

        ea = $urandom_range(0, 90);
        e  = (ea > DEPTH - 1) ? DEPTH - 1 : ea;
        dv = $urandom_range(0, 3);
        lp = $urandom_range(0, 1);
        p  = dv + 1;
        for (int i = 0; i <= e; i++) begin
            seq_one.push_back(i);
            seq_loop.push_back(i);
        end
`ifdef DC_PINGPONG_EN
        for (int i = e - 1; i >= 0; i--) seq_one.push_back(i);
        for (int i = e - 1; i >= 1; i--) seq_loop.push_back(i);
`endif
        run_len = seq_one.size() * p;
        if (lp != 0) stop_at = $urandom_range(1, 200);
        else if ($urandom_range(0, 3) == 0) stop_at = $urandom_range(0, run_len);
        else stop_at = -1;

        ms = 0;
        k = 0;
        idle_seen = 0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 0) begin
                end_addr = AW'(ea);
                div      = DIV_W'(dv);
                loop     = lp[0];
                start    = 1'b1;
                stop     = 1'($urandom_range(0, 1));
            end else begin
                end_addr = AW'($urandom_range(0, 127));
                div      = DIV_W'($urandom_range(0, 255));
                loop     = 1'($urandom_range(0, 1));
                start    = (ms == 1) && ($urandom_range(0, 9) == 0);
                stop     = (ms == 1) ? (k == stop_at) : ($urandom_range(0, 3) == 0);
            end
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = AW'($urandom_range(0, 127));
            wr_data = WIDTH'($urandom);

            case (ms)
                0: if (start) begin ms = 1; k = 0; end
                1: begin
                    a = (lp != 0) ? seq_loop[(k / p) % seq_loop.size()] : seq_one[k / p];
                    m_dcx = mem[a];
                    if (stop) ms = 0;
                    else if (lp == 0 && k == run_len - 1) ms = 2;
                    else k++;
                end
                default: ms = 0;
            endcase
            if (wr_en && wr_addr < DEPTH) mem[wr_addr] = wr_data;

            @(negedge sysclk);
            check($sformatf("rand%0d_dcx", run_id), dc_x, m_dcx);
            check($sformatf("rand%0d_busy", run_id), busy, (ms == 1) ? 1 : 0);
            check($sformatf("rand%0d_done", run_id), done, (ms == 2) ? 1 : 0);
            if (ms == 0) idle_seen++;
            if (idle_seen == 2) begin
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        wr_en = 1'b0;
        if (!finished) check($sformatf("rand%0d_timeout", run_id), 0, 1);
    endtask

    initial begin
        // Reset values, reached asynchronously before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("reset_dcx", dc_x, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(negedge sysclk);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) write_word(i, i + 1);
        write_word(70, 42);

        // {end_addr, div, loop, cycle after start, DC_X, busy, done}; table holds ram[i]=i+1 mod 64.
`ifdef DC_PINGPONG_EN
        add_vec(7, 0, 0, 0, 0, 1, 0);
        add_vec(7, 0, 0, 1, 1, 1, 0);
        add_vec(7, 0, 0, 7, 7, 1, 0);
        add_vec(7, 0, 0, 8, 8, 1, 0);
        add_vec(7, 0, 0, 9, 7, 1, 0);
        add_vec(7, 0, 0, 15, 1, 0, 1);
        add_vec(7, 0, 0, 16, 1, 0, 0);
        add_vec(3, 0, 0, 4, 4, 1, 0);
        add_vec(3, 0, 0, 5, 3, 1, 0);
        add_vec(3, 0, 0, 7, 1, 0, 1);
        add_vec(3, 3, 1, 25, 1, 1, 0);
        add_vec(3, 3, 1, 29, 2, 1, 0);
        add_vec(70, 0, 0, 64, 0, 1, 0);
        add_vec(70, 0, 0, 65, 63, 1, 0);
`else
        add_vec(7, 0, 0, 0, 0, 1, 0);
        add_vec(7, 0, 0, 1, 1, 1, 0);
        add_vec(7, 0, 0, 5, 5, 1, 0);
        add_vec(7, 0, 0, 7, 7, 1, 0);
        add_vec(7, 0, 0, 8, 8, 0, 1);
        add_vec(7, 0, 0, 9, 8, 0, 0);
        add_vec(7, 3, 1, 4, 1, 1, 0);
        add_vec(7, 3, 1, 5, 2, 1, 0);
        add_vec(7, 3, 1, 32, 8, 1, 0);
        add_vec(7, 3, 1, 33, 1, 1, 0);
        add_vec(70, 0, 0, 63, 63, 1, 0);
        add_vec(70, 0, 0, 64, 0, 0, 1);
`endif
        add_vec(0, 0, 0, 1, 1, 0, 1);
        add_vec(0, 0, 0, 2, 1, 0, 0);
        add_vec(0, 2, 1, 10, 1, 1, 0);

        foreach (vecs[i]) begin
            do_reset();
            start_run(vecs[i].ea, vecs[i].dv, vecs[i].lp);
            repeat (vecs[i].k) @(negedge sysclk);
            check($sformatf("vec%0d_dcx", i), dc_x, vecs[i].dcx);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
            check($sformatf("vec%0d_done", i), done, vecs[i].dn);
        end

        // Start ignored in RUN, then stop during cycle 4 freezes DC_X at entry 4 (value 5).
        do_reset();
        start_run(7, 0, 1);
        repeat (3) @(negedge sysclk);
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        check("run_start_ignored", dc_x, 4);
        stop = 1'b1;
        @(negedge sysclk);
        stop = 1'b0;
        check("stop_dcx", dc_x, 5);
        check("stop_busy", busy, 0);
        check("stop_done", done, 0);
        repeat (3) @(negedge sysclk);
        check("stop_hold_dcx", dc_x, 5);
        check("stop_hold_done", done, 0);

        // Asynchronous reset mid-run, then a fresh run starts from address 0.
        do_reset();
        start_run(7, 3, 1);
        repeat (10) @(negedge sysclk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_dcx", dc_x, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        @(negedge sysclk);
        rst_n = 1'b1;
        check("post_rst_done", done, 0);
        start_run(7, 0, 0);
        @(negedge sysclk);
        check("post_rst_first", dc_x, 1);

        // Write and read of the same address on the same edge returns the old word.
        do_reset();
        start_run(0, 0, 1);
        repeat (2) @(negedge sysclk);
        write_word(0, 33);
        check("collide_old", dc_x, 1);
        @(negedge sysclk);
        check("collide_new", dc_x, 33);
        stop = 1'b1;
        @(negedge sysclk);
        stop = 1'b0;
        write_word(0, 1);

        do_reset();
        m_dcx = 0;
        for (int r = 0; r < 40; r++) random_run(r);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
